// File: rtl/dadda_mul_arbiter_pkg.sv
// ============================================================================
// Package  : dadda_arb_pkg
// Purpose  : Shared types and widths for the shared Dadda multiplier arbiter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package dadda_arb_pkg;

   // Sequencing of one shared multiply: grant, evaluate, hold result.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   localparam int MUL_WIDTH = 8;
   localparam int PRODUCT_W = 2 * MUL_WIDTH;

endpackage

`default_nettype wire

// File: rtl/if_multiplier.sv
// ============================================================================
// Interface: if_multiplier
// Purpose  : Operand/result bundle of the 8x8 Dadda multiplier. The product's
//            top bit is carried separately as the overflow flag.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface if_multiplier;
   import dadda_arb_pkg::*;

   logic [MUL_WIDTH-1:0] in1;
   logic [MUL_WIDTH-1:0] in2;
   logic [PRODUCT_W-2:0] out;
   logic                 overflow;

   modport mul  (input  in1, input  in2, output out, output overflow);
   modport user (output in1, output in2, input  out, input  overflow);
endinterface

`default_nettype wire

// File: rtl/dadda_8.sv
// ============================================================================
// Module   : dadda_8
// Purpose  : Exact unsigned 8x8 multiplier. Partial products are reduced by a
//            chain of 3:2 carry-save compressors, then one final carry add.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dadda_8
   import dadda_arb_pkg::*;
(
   if_multiplier.mul muif
);

   logic [PRODUCT_W-1:0] pp [MUL_WIDTH];
   logic [PRODUCT_W-1:0] prod;

   // Carry-save reduction of the shifted partial products.
   always_comb begin : csa_tree
      logic [PRODUCT_W-1:0] s;
      logic [PRODUCT_W-1:0] c;
      logic [PRODUCT_W-1:0] t;
      for (int i = 0; i < MUL_WIDTH; i++) begin
         pp[i] = PRODUCT_W'(muif.in1 & {MUL_WIDTH{muif.in2[i]}}) << i;
      end
      s = pp[0];
      c = pp[1];
      t = '0;
      for (int i = 2; i < MUL_WIDTH; i++) begin
         t = (s & c) | (s & pp[i]) | (c & pp[i]);
         s = s ^ c ^ pp[i];
         c = t << 1;
      end
      prod = s + c;
   end

   assign muif.out      = prod[PRODUCT_W-2:0];
   assign muif.overflow = prod[PRODUCT_W-1];

endmodule

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin grant. Picks the first valid requester
//            at or after ptr_i, wrapping modulo NUM_REQ. One-hot or zero.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic [NUM_REQ-1:0] grant_o
);

   localparam logic [ID_W:0] N_W = (ID_W+1)'(NUM_REQ);

   // Walk the requesters starting at the pointer; first valid one wins.
   always_comb begin : grant_search
      logic [ID_W:0] pos;
      logic          found;
      grant_o = '0;
      found   = 1'b0;
      pos     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         pos = {1'b0, ptr_i} + (ID_W+1)'(k);
         if (pos >= N_W) begin
            pos = pos - N_W;
         end
         if (!found && valid_i[pos[ID_W-1:0]]) begin
            grant_o[pos[ID_W-1:0]] = 1'b1;
            found                  = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/dadda_mul_arbiter.sv
// ============================================================================
// Module   : dadda_mul_arbiter
// Purpose  : Shares one dadda_8 multiplier among NUM_REQ requesters using
//            round-robin arbitration, a one-cycle evaluate stage and a held,
//            backpressured response.
// Options  : DADDA_ARB_STATS_EN adds saturating op_count / stall_count ports.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dadda_mul_arbiter
   import dadda_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = MUL_WIDTH,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ID_W-1:0]          rsp_id,
   output logic [2*WIDTH-1:0]       rsp_product,
   output logic                     busy
`ifdef DADDA_ARB_STATS_EN
   ,
   output logic [31:0]              op_count,
   output logic [31:0]              stall_count
`endif
);

   localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

   arb_state_t          state_q, state_d;
   logic [ID_W-1:0]     ptr_q, ptr_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0]    op_a_q, op_a_d;
   logic [WIDTH-1:0]    op_b_q, op_b_d;
   logic                rsp_valid_q, rsp_valid_d;
   logic [2*WIDTH-1:0]  rsp_product_q, rsp_product_d;

   logic [NUM_REQ-1:0]  grant;
   logic [ID_W-1:0]     grant_idx;
   logic [WIDTH-1:0]    sel_a;
   logic [WIDTH-1:0]    sel_b;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr (
      .valid_i (req_valid),
      .ptr_i   (ptr_q),
      .grant_o (grant)
   );

   if_multiplier muif ();

   dadda_8 u_mul (
      .muif (muif)
   );

   assign muif.in1 = op_a_q;
   assign muif.in2 = op_b_q;

   // Decode the one-hot grant into an index and the granted operand slices.
   always_comb begin
      grant_idx = '0;
      sel_a     = '0;
      sel_b     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            grant_idx = ID_W'(i);
            sel_a     = req_a[i*WIDTH +: WIDTH];
            sel_b     = req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   // Next-state logic: accept one request, evaluate for a cycle, hold result.
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      id_d          = id_q;
      op_a_d        = op_a_q;
      op_b_d        = op_b_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_id_d      = rsp_id_q;
      rsp_product_d = rsp_product_q;
      case (state_q)
         IDLE: begin
            if (|grant) begin
               op_a_d  = sel_a;
               op_b_d  = sel_b;
               id_d    = grant_idx;
               ptr_d   = (grant_idx == LAST_ID) ? '0 : grant_idx + ID_W'(1);
               state_d = CALC;
            end
         end
         CALC: begin
            rsp_product_d = {muif.overflow, muif.out};
            rsp_id_d      = id_q;
            rsp_valid_d   = 1'b1;
            state_d       = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; reset discards any in-flight operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         ptr_q         <= '0;
         id_q          <= '0;
         op_a_q        <= '0;
         op_b_q        <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_id_q      <= '0;
         rsp_product_q <= '0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         id_q          <= id_d;
         op_a_q        <= op_a_d;
         op_b_q        <= op_b_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_id_q      <= rsp_id_d;
         rsp_product_q <= rsp_product_d;
      end
   end

   // Grants only in IDLE, and never while reset is asserted.
   assign req_ready   = (state_q == IDLE && rst_n) ? grant : '0;
   assign busy        = (state_q != IDLE);
   assign rsp_valid   = rsp_valid_q;
   assign rsp_id      = rsp_id_q;
   assign rsp_product = rsp_product_q;

`ifdef DADDA_ARB_STATS_EN
   logic [31:0] op_count_q;
   logic [31:0] stall_count_q;

   // Saturating counters of completed handshakes and backpressured cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count_q    <= '0;
         stall_count_q <= '0;
      end else begin
         if (state_q == RESP && rsp_ready && !(&op_count_q)) begin
            op_count_q <= op_count_q + 32'd1;
         end
         if (state_q == RESP && !rsp_ready && !(&stall_count_q)) begin
            stall_count_q <= stall_count_q + 32'd1;
         end
      end
   end

   assign op_count    = op_count_q;
   assign stall_count = stall_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dadda_mul_arbiter.sv
// ============================================================================
// Module   : tb_dadda_mul_arbiter
// Purpose  : Self-checking bench for dadda_mul_arbiter with a transaction-level
//            reference model, directed scenarios and randomized traffic.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dadda_mul_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int IW = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_a = '0;
   logic [N*W-1:0] req_b = '0;
   logic           rsp_valid;
   logic           rsp_ready = 1'b0;
   logic [IW-1:0]  rsp_id;
   logic [2*W-1:0] rsp_product;
   logic           busy;
`ifdef DADDA_ARB_STATS_EN
   logic [31:0]    op_count;
   logic [31:0]    stall_count;
`endif

   always #5 clk = ~clk;

   dadda_mul_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_id      (rsp_id),
      .rsp_product (rsp_product),
      .busy        (busy)
`ifdef DADDA_ARB_STATS_EN
      ,
      .op_count    (op_count),
      .stall_count (stall_count)
`endif
   );

   int n_err    = 0;
   int n_checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (transaction level) ----------------
   // A job is taken when the block is free; its result is visible two cycles
   // after acceptance and stays until the consumer takes it.
   bit          m_job    = 1'b0;
   int          m_age    = 0;
   int          m_ptr    = 0;
   logic [7:0]  m_a      = '0;
   logic [7:0]  m_b      = '0;
   int          m_id     = 0;
   logic [31:0] m_ops    = '0;
   logic [31:0] m_stalls = '0;
   logic [N-1:0] hs_last = '0;

   function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int ptr);
      logic [N-1:0] one;
      one = 1;
      for (int k = 0; k < N; k++) begin
         int j;
         j = (ptr + k) % N;
         if (v[j]) return one << j;
      end
      return '0;
   endfunction

   always @(negedge clk) begin
      logic [N-1:0] eg;
      logic         ev;
      int           gi;
      if (!rst_n) begin
         m_job = 1'b0; m_age = 0; m_ptr = 0; m_ops = '0; m_stalls = '0; hs_last = '0;
      end else begin
         ev = m_job && (m_age >= 2);
         eg = m_job ? '0 : rr_pick(req_valid, m_ptr);
         chk("req_ready", 32'(req_ready), 32'(eg));
         chk("busy", 32'(busy), 32'(m_job));
         chk("rsp_valid", 32'(rsp_valid), 32'(ev));
         if (ev) begin
            chk("rsp_product", 32'(rsp_product), 32'(m_a) * 32'(m_b));
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
         end
`ifdef DADDA_ARB_STATS_EN
         chk("op_count", op_count, m_ops);
         chk("stall_count", stall_count, m_stalls);
`endif
         hs_last = req_valid & req_ready;
         if (!m_job) begin
            if (eg != '0) begin
               gi = 0;
               for (int i = 0; i < N; i++) if (eg[i]) gi = i;
               m_job = 1'b1;
               m_age = 1;
               m_a   = req_a[gi*W +: W];
               m_b   = req_b[gi*W +: W];
               m_id  = gi;
               m_ptr = (gi + 1) % N;
            end
         end else if (m_age < 2) begin
            m_age++;
         end else if (rsp_ready) begin
            m_job = 1'b0;
            if (m_ops != 32'hFFFF_FFFF) m_ops++;
         end else begin
            if (m_stalls != 32'hFFFF_FFFF) m_stalls++;
         end
      end
   end

   // Requester obligation: a held, ungranted request keeps its operands.
   logic [N-1:0] pend_q = '0;
   logic [7:0]   pa [N];
   logic [7:0]   pb [N];
   always @(negedge clk) begin
      if (!rst_n) begin
         pend_q = '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (pend_q[i] && req_valid[i])
               assert (req_a[i*W +: W] == pa[i] && req_b[i*W +: W] == pb[i])
                  else $error("requester %0d altered a held request", i);
            pend_q[i] = req_valid[i] & ~req_ready[i];
            pa[i]     = req_a[i*W +: W];
            pb[i]     = req_b[i*W +: W];
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic set_req(input int idx, input logic [7:0] a, input logic [7:0] b);
      req_a[idx*W +: W] = a;
      req_b[idx*W +: W] = b;
   endtask

   task automatic do_op(input int idx, input logic [7:0] a, input logic [7:0] b, input int stalls);
      set_req(idx, a, b);
      req_valid      = '0;
      req_valid[idx] = 1'b1;
      rsp_ready      = 1'b0;
      cyc();
      req_valid = '0;
      cyc();
      repeat (stalls) cyc();
      rsp_ready = 1'b1;
      cyc();
      rsp_ready = 1'b0;
   endtask

   function automatic logic [7:0] rand_op();
      case ($urandom_range(0, 5))
         0:       return 8'h00;
         1:       return 8'hFF;
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   int g_idx[$];
   int g_cyc[$];

   initial begin
      // ---- reset state ----
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      smp();
      chk("reset_req_ready", 32'(req_ready), 32'h0);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("reset_rsp_id", 32'(rsp_id), 32'h0);
      chk("reset_rsp_product", 32'(rsp_product), 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);

      // ---- single request from requester 2: 13*11 ----
      cyc();
      set_req(2, 8'd13, 8'd11);
      req_valid = 4'b0100;
      smp();
      chk("single_grant", 32'(req_ready), 32'h4);
      cyc();
      req_valid = '0;
      rsp_ready = 1'b1;            // ignored while no response is valid
      smp();
      chk("single_busy_calc", 32'(busy), 32'h1);
      chk("single_no_rsp_calc", 32'(rsp_valid), 32'h0);
      cyc();
      smp();
      chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("single_product", 32'(rsp_product), 32'd143);
      chk("single_id", 32'(rsp_id), 32'd2);
      cyc();
      smp();
      chk("single_idle_busy", 32'(busy), 32'h0);
      chk("single_idle_valid", 32'(rsp_valid), 32'h0);

      // ---- wrap/skip: pointer at 3, only requester 1 valid ----
      cyc();
      set_req(1, 8'd200, 8'd3);
      req_valid = 4'b0010;
      smp();
      chk("wrap_grant", 32'(req_ready), 32'h2);
      cyc();
      req_valid = '0;
      cyc();
      smp();
      chk("wrap_product", 32'(rsp_product), 32'd600);
      chk("wrap_id", 32'(rsp_id), 32'd1);

      // ---- pointer now 2; max operands with 5 cycles of backpressure ----
      cyc();
      set_req(1, 8'd9, 8'd4);
      set_req(2, 8'hFF, 8'hFF);
      set_req(3, 8'd5, 8'd6);
      req_valid = 4'b1110;
      rsp_ready = 1'b0;
      smp();
      chk("ptr_after_wrap_grant", 32'(req_ready), 32'h4);
      cyc();
      set_req(0, 8'd77, 8'd88);
      req_valid = 4'b1011;
      smp();
      chk("max_busy", 32'(busy), 32'h1);
      for (int k = 0; k < 5; k++) begin
         cyc();
         smp();
         chk("max_hold_valid", 32'(rsp_valid), 32'h1);
         chk("max_hold_product", 32'(rsp_product), 32'hFE01);
         chk("max_hold_id", 32'(rsp_id), 32'd2);
         chk("max_hold_no_grant", 32'(req_ready), 32'h0);
      end
      cyc();
      rsp_ready = 1'b1;
      smp();
      chk("max_accept_valid", 32'(rsp_valid), 32'h1);
      cyc();
      rsp_ready = 1'b0;
      smp();
      chk("max_back_idle", 32'(busy), 32'h0);
      chk("max_next_grant", 32'(req_ready), 32'h8);
      cyc();
      req_valid = '0;
      rsp_ready = 1'b1;
      cyc();
      cyc();

      // ---- asynchronous reset during CALC ----
      set_req(1, 8'd7, 8'd9);
      req_valid = 4'b0010;
      cyc();
      set_req(2, 8'd3, 8'd3);
      req_valid = 4'b0100;
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_req_ready", 32'(req_ready), 32'h0);
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("midrst_rsp_id", 32'(rsp_id), 32'h0);
      chk("midrst_rsp_product", 32'(rsp_product), 32'h0);
      chk("midrst_busy", 32'(busy), 32'h0);
      req_valid = '0;
      cyc();
      cyc();
      #1 rst_n = 1'b1;

      // ---- fairness: all requesters valid, consumer always ready ----
      cyc();
      for (int i = 0; i < N; i++) set_req(i, 8'(i * 17 + 3), 8'(i * 29 + 7));
      req_valid = 4'b1111;
      rsp_ready = 1'b1;
      for (int c = 0; c < 18; c++) begin
         smp();
         for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
               g_idx.push_back(i);
               g_cyc.push_back(c);
            end
         end
         cyc();
      end
      req_valid = '0;
      chk("fair_grant_count", 32'(g_idx.size()), 32'd6);
      for (int k = 0; k < 6 && k < g_idx.size(); k++) begin
         chk("fair_order", 32'(g_idx[k]), 32'(k % N));
         chk("fair_spacing", 32'(g_cyc[k]), 32'(3 * k));
      end
      cyc();
      cyc();
      cyc();

      // ---- statistics: 3 operations with 2 stall cycles ----
      rst_n = 1'b0;
      cyc();
      cyc();
      #1 rst_n = 1'b1;
      cyc();
      do_op(0, 8'd10, 8'd20, 1);
      do_op(1, 8'd128, 8'd2, 1);
      do_op(2, 8'd255, 8'd1, 0);
      smp();
      chk("stats_idle", 32'(busy), 32'h0);
`ifdef DADDA_ARB_STATS_EN
      chk("stats_op_count", op_count, 32'd3);
      chk("stats_stall_count", stall_count, 32'd2);
`endif

      // ---- randomized traffic ----
      cyc();
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < N; i++) begin
            if (hs_last[i]) begin
               req_valid[i] = 1'($urandom_range(0, 1));
               set_req(i, rand_op(), rand_op());
            end else if (!req_valid[i]) begin
               if ($urandom_range(0, 3) == 0) begin
                  req_valid[i] = 1'b1;
                  set_req(i, rand_op(), rand_op());
               end
            end else if ($urandom_range(0, 15) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         rsp_ready = ($urandom_range(0, 2) != 0);
         if (n == 1500) begin
            #1 rst_n = 1'b0;
            cyc();
            #1 rst_n = 1'b1;
         end
         cyc();
      end

      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (6) cyc();
      smp();
      chk("final_idle", 32'(busy), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
